// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multicycle controller and the datapath ALU.
package cpu_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LH    = 6'b100001;
   localparam logic [5:0] OP_SH    = 6'b101001;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_SLL = 6'b000000;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SLL = 3'b011;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_TIMEOUT = 2'b01;
   localparam logic [1:0] ERR_ILLEGAL = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_EXEC,
      S_ALU_WB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_TRAP
   } state_t;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// R-type funct decode: ALU operation, shift select and legality.
module alu_decoder
   import cpu_ctrl_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] alu_op,
   output logic       shift,
   output logic       legal
);

   always_comb begin
      alu_op = ALU_ADD;
      shift  = 1'b0;
      legal  = 1'b1;
      case (funct)
         FN_ADD:  alu_op = ALU_ADD;
         FN_SUB:  alu_op = ALU_SUB;
         FN_AND:  alu_op = ALU_AND;
         FN_OR:   alu_op = ALU_OR;
         FN_SLT:  alu_op = ALU_SLT;
         FN_SLL: begin
            alu_op = ALU_SLL;
            shift  = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore controller for the shared-memory multicycle datapath, with memory
// watchdog and illegal-instruction trap.
//   FETCH: read instr | DECODE: branch target | MEM_ADDR: ld/st address
//   MEM_RD/MEM_WB: load | MEM_WR: store | EXEC/ALU_WB: R-type
//   ADDI_EX/ADDI_WB: addi | BRANCH: beq | JUMP: j | TRAP: halted until reset
module multicycle_control_unit
   import cpu_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W  = 3,
   parameter int MEM_TIMEOUT = 16,
   parameter int HALFWORD_EN = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [5:0]            opcode,
   input  logic [5:0]            funct,
   input  logic                  zero,
   input  logic                  mem_ready,
   output logic                  pc_write,
   output logic                  pc_write_cond,
   output logic                  iord,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic                  ir_write,
   output logic                  reg_write,
   output logic                  reg_dst,
   output logic                  mem_to_reg,
   output logic                  alu_src_a,
   output logic                  half_word,
   output logic                  shift,
   output logic [1:0]            alu_src_b,
   output logic [1:0]            pc_source,
   output logic [ALU_CTRL_W-1:0] alu_control,
   output logic                  instr_retired,
   output logic                  err,
   output logic [1:0]            err_code
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       err_code_q, err_code_d;
   logic             hw_ok, half_op, is_load, is_store, waiting, timeout;
   logic [2:0]       rt_alu, alu3;
   logic             rt_shift, rt_legal;
   logic             unused_zero;

   // Branch resolution happens in the datapath's PC write gate.
   assign unused_zero = zero;

   alu_decoder u_alu_dec (
      .funct  (funct),
      .alu_op (rt_alu),
      .shift  (rt_shift),
      .legal  (rt_legal)
   );

   assign hw_ok    = (HALFWORD_EN != 0);
   assign half_op  = (opcode == OP_LH) || (opcode == OP_SH);
   assign is_load  = (opcode == OP_LW) || ((opcode == OP_LH) && hw_ok);
   assign is_store = (opcode == OP_SW) || ((opcode == OP_SH) && hw_ok);
   assign waiting  = !mem_ready &&
                     (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR);
   assign timeout  = waiting && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d    = state_q;
      err_code_d = err_code_q;
      case (state_q)
         S_FETCH: begin
            if (timeout) begin
               state_d    = S_TRAP;
               err_code_d = ERR_TIMEOUT;
            end else if (mem_ready) begin
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (is_load || is_store)                 state_d = S_MEM_ADDR;
            else if (opcode == OP_RTYPE && rt_legal) state_d = S_EXEC;
            else if (opcode == OP_ADDI)              state_d = S_ADDI_EX;
            else if (opcode == OP_BEQ)               state_d = S_BRANCH;
            else if (opcode == OP_J)                 state_d = S_JUMP;
            else begin
               state_d    = S_TRAP;
               err_code_d = ERR_ILLEGAL;
            end
         end
         S_MEM_ADDR: state_d = is_store ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD, S_MEM_WR: begin
            if (timeout) begin
               state_d    = S_TRAP;
               err_code_d = ERR_TIMEOUT;
            end else if (mem_ready) begin
               state_d = (state_q == S_MEM_RD) ? S_MEM_WB : S_FETCH;
            end
         end
         S_EXEC:    state_d = S_ALU_WB;
         S_ADDI_EX: state_d = S_ADDI_WB;
         S_TRAP:    state_d = S_TRAP;
         default:   state_d = S_FETCH;
      endcase
      cnt_d = (waiting && state_d == state_q) ? cnt_q + CNT_W'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_FETCH;
         cnt_q      <= '0;
         err_code_q <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         err_code_q <= err_code_d;
      end
   end

   always_comb begin
      pc_write = 1'b0; pc_write_cond = 1'b0; iord = 1'b0; mem_read = 1'b0;
      mem_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0; reg_dst = 1'b0;
      mem_to_reg = 1'b0; alu_src_a = 1'b0; half_word = 1'b0; shift = 1'b0;
      alu_src_b = 2'b00; pc_source = 2'b00; alu3 = ALU_AND;
      instr_retired = 1'b0; err = 1'b0; err_code = ERR_NONE;
      if (!reset) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = 2'b01;
               alu3      = ALU_ADD;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
            end
            S_DECODE: begin
               alu_src_b = 2'b11;
               alu3      = ALU_ADD;
            end
            S_MEM_ADDR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu3      = ALU_ADD;
               half_word = half_op && hw_ok;
            end
            S_MEM_RD: begin
               iord      = 1'b1;
               mem_read  = 1'b1;
               half_word = half_op && hw_ok;
            end
            S_MEM_WB: begin
               reg_write     = 1'b1;
               mem_to_reg    = 1'b1;
               instr_retired = 1'b1;
               half_word     = half_op && hw_ok;
            end
            S_MEM_WR: begin
               iord          = 1'b1;
               mem_write     = 1'b1;
               instr_retired = mem_ready;
               half_word     = half_op && hw_ok;
            end
            S_EXEC: begin
               alu_src_a = 1'b1;
               alu3      = rt_alu;
               shift     = rt_shift;
            end
            S_ALU_WB: begin
               reg_write     = 1'b1;
               reg_dst       = 1'b1;
               alu3          = rt_alu;
               shift         = rt_shift;
               instr_retired = 1'b1;
            end
            S_ADDI_EX: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu3      = ALU_ADD;
            end
            S_ADDI_WB: begin
               reg_write     = 1'b1;
               alu3          = ALU_ADD;
               instr_retired = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a     = 1'b1;
               alu3          = ALU_SUB;
               pc_write_cond = 1'b1;
               pc_source     = 2'b01;
               instr_retired = 1'b1;
            end
            S_JUMP: begin
               pc_write      = 1'b1;
               pc_source     = 2'b10;
               instr_retired = 1'b1;
            end
            S_TRAP: begin
               err      = 1'b1;
               err_code = err_code_q;
            end
            default: ;
         endcase
      end
      alu_control = ALU_CTRL_W'(alu3);
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: two controllers (short watchdog with halfwords, default
// watchdog without halfwords) driven in lockstep, outputs scored per cycle.
module tb_multicycle_control_unit;

   localparam int T_FETCH = 0, T_DECODE = 1, T_MEM_ADDR = 2, T_MEM_RD = 3,
                  T_MEM_WB = 4, T_MEM_WR = 5, T_EXEC = 6, T_ALU_WB = 7,
                  T_ADDI_EX = 8, T_ADDI_WB = 9, T_BRANCH = 10, T_JUMP = 11,
                  T_TRAP = 12, T_RST = 13;

   logic       clk, reset, zero, mem_ready;
   logic [5:0] opcode, funct;

   logic pw_a, pwc_a, iord_a, mrd_a, mwr_a, irw_a, rw_a, rdst_a, m2r_a, sa_a, hw_a, sh_a, ret_a, err_a;
   logic pw_b, pwc_b, iord_b, mrd_b, mwr_b, irw_b, rw_b, rdst_b, m2r_b, sa_b, hw_b, sh_b, ret_b, err_b;
   logic [1:0] sb_a, pcs_a, ec_a, sb_b, pcs_b, ec_b;
   logic [2:0] alu_a, alu_b;
   logic [22:0] obs_a, obs_b;

   assign obs_a = {pw_a, pwc_a, iord_a, mrd_a, mwr_a, irw_a, rw_a, rdst_a, m2r_a, sa_a,
                   hw_a, sh_a, sb_a, pcs_a, alu_a, ret_a, err_a, ec_a};
   assign obs_b = {pw_b, pwc_b, iord_b, mrd_b, mwr_b, irw_b, rw_b, rdst_b, m2r_b, sa_b,
                   hw_b, sh_b, sb_b, pcs_b, alu_b, ret_b, err_b, ec_b};

   multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_TIMEOUT(4), .HALFWORD_EN(1)) dut_a (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pw_a), .pc_write_cond(pwc_a), .iord(iord_a),
      .mem_read(mrd_a), .mem_write(mwr_a), .ir_write(irw_a), .reg_write(rw_a),
      .reg_dst(rdst_a), .mem_to_reg(m2r_a), .alu_src_a(sa_a), .half_word(hw_a),
      .shift(sh_a), .alu_src_b(sb_a), .pc_source(pcs_a), .alu_control(alu_a),
      .instr_retired(ret_a), .err(err_a), .err_code(ec_a));

   multicycle_control_unit #(.ALU_CTRL_W(3), .MEM_TIMEOUT(16), .HALFWORD_EN(0)) dut_b (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .pc_write(pw_b), .pc_write_cond(pwc_b), .iord(iord_b),
      .mem_read(mrd_b), .mem_write(mwr_b), .ir_write(irw_b), .reg_write(rw_b),
      .reg_dst(rdst_b), .mem_to_reg(m2r_b), .alu_src_a(sa_b), .half_word(hw_b),
      .shift(sh_b), .alu_src_b(sb_b), .pc_source(pcs_b), .alu_control(alu_b),
      .instr_retired(ret_b), .err(err_b), .err_code(ec_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [22:0] e;
      bit          b;
      int          st;
   } sb_t;

   sb_t        sb_q[$];
   int         errors = 0;
   int         checks = 0;
   logic [1:0] exp_ec, exp_ec_b;
   logic [5:0] rfn [6] = '{6'b100010, 6'b100000, 6'b100100, 6'b100101, 6'b101010, 6'b000000};

   function automatic logic [2:0] exp_alu(input logic [5:0] fn);
      case (fn)
         6'b100000: return 3'b010;
         6'b100010: return 3'b110;
         6'b100100: return 3'b000;
         6'b100101: return 3'b001;
         6'b101010: return 3'b111;
         6'b000000: return 3'b011;
         default:   return 3'b010;
      endcase
   endfunction

   function automatic logic [22:0] expo(input int st, input logic [5:0] op,
                                        input logic [5:0] fn, input logic rdy,
                                        input logic [1:0] ec);
      logic pw, pwc, io, mrd, mwr, irw, rw, rdst, m2r, sa, hw, sh, ret, er;
      logic [1:0] sb, pcs, e;
      logic [2:0] alu;
      logic hop;
      {pw, pwc, io, mrd, mwr, irw, rw, rdst, m2r, sa, hw, sh, ret, er} = '0;
      sb = 2'b00; pcs = 2'b00; e = 2'b00; alu = 3'b000;
      hop = (op == 6'b100001) || (op == 6'b101001);
      case (st)
         T_FETCH:    begin mrd = 1; sb = 2'b01; alu = 3'b010; irw = rdy; pw = rdy; end
         T_DECODE:   begin sb = 2'b11; alu = 3'b010; end
         T_MEM_ADDR: begin sa = 1; sb = 2'b10; alu = 3'b010; hw = hop; end
         T_MEM_RD:   begin io = 1; mrd = 1; hw = hop; end
         T_MEM_WB:   begin rw = 1; m2r = 1; ret = 1; hw = hop; end
         T_MEM_WR:   begin io = 1; mwr = 1; ret = rdy; hw = hop; end
         T_EXEC:     begin sa = 1; alu = exp_alu(fn); sh = (fn == 6'b000000); end
         T_ALU_WB:   begin rw = 1; rdst = 1; alu = exp_alu(fn); sh = (fn == 6'b000000); ret = 1; end
         T_ADDI_EX:  begin sa = 1; sb = 2'b10; alu = 3'b010; end
         T_ADDI_WB:  begin rw = 1; alu = 3'b010; ret = 1; end
         T_BRANCH:   begin sa = 1; alu = 3'b110; pwc = 1; pcs = 2'b01; ret = 1; end
         T_JUMP:     begin pw = 1; pcs = 2'b10; ret = 1; end
         T_TRAP:     begin er = 1; e = ec; end
         default:    ;
      endcase
      return {pw, pwc, io, mrd, mwr, irw, rw, rdst, m2r, sa, hw, sh, sb, pcs, alu, ret, er, e};
   endfunction

   task automatic cyc(input int st, input logic rdy, input int st_b = -1);
      sb_t         it;
      logic [22:0] obs;
      string       tag;
      mem_ready = rdy;
      it.e = expo(st, opcode, funct, rdy, exp_ec); it.b = 1'b0; it.st = st;
      sb_q.push_back(it);
      if (st_b >= 0) begin
         it.e = expo(st_b, opcode, funct, rdy, exp_ec_b); it.b = 1'b1; it.st = st_b;
         sb_q.push_back(it);
      end
      @(negedge clk);
      while (sb_q.size() > 0) begin
         it  = sb_q.pop_front();
         obs = it.b ? obs_b : obs_a;
         tag = it.b ? "dut_b" : "dut_a";
         checks++;
         assert (obs === it.e) else begin
            errors++;
            $error("FAIL %s chk%0d st=%0d observed=%06h expected=%06h", tag, checks, it.st, obs, it.e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc(T_RST, 1'b0, T_RST);
      reset = 1'b0;
      exp_ec   = 2'b00;
      exp_ec_b = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; zero = 1'b0; mem_ready = 1'b0; opcode = '0; funct = '0;
      exp_ec = 2'b00; exp_ec_b = 2'b00;
      @(posedge clk); #1;
      cyc(T_RST, 1'b1, T_RST);
      do_reset();

      // lw with memory always ready
      opcode = 6'b100011;
      cyc(T_FETCH, 1, T_FETCH); cyc(T_DECODE, 1, T_DECODE); cyc(T_MEM_ADDR, 1, T_MEM_ADDR);
      cyc(T_MEM_RD, 1, T_MEM_RD); cyc(T_MEM_WB, 1, T_MEM_WB);

      // addi after three fetch waits: cnt hits MEM_TIMEOUT-1 on dut_a, no trap
      opcode = 6'b001000;
      cyc(T_FETCH, 0, T_FETCH); cyc(T_FETCH, 0, T_FETCH); cyc(T_FETCH, 0, T_FETCH);
      cyc(T_FETCH, 1, T_FETCH); cyc(T_DECODE, 1, T_DECODE);
      cyc(T_ADDI_EX, 1, T_ADDI_EX); cyc(T_ADDI_WB, 1, T_ADDI_WB);

      opcode = 6'b000100;
      zero = 1'b1;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_BRANCH, 1);
      zero = 1'b0;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_BRANCH, 1, T_BRANCH);

      opcode = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         funct = rfn[i];
         cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_EXEC, 1, T_EXEC); cyc(T_ALU_WB, 1, T_ALU_WB);
      end

      opcode = 6'b000010;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_JUMP, 1, T_JUMP);

      // sh/lh: legal on dut_a, illegal on dut_b
      opcode = 6'b101001;
      exp_ec_b = 2'b10;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_MEM_ADDR, 1, T_TRAP);
      cyc(T_MEM_WR, 0); cyc(T_MEM_WR, 1);
      opcode = 6'b100001;
      cyc(T_FETCH, 1, T_TRAP); cyc(T_DECODE, 1); cyc(T_MEM_ADDR, 1);
      cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 1); cyc(T_MEM_WB, 1, T_TRAP);
      do_reset();

      opcode = 6'b111111;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1);
      exp_ec = 2'b10; exp_ec_b = 2'b10;
      cyc(T_TRAP, 1, T_TRAP); cyc(T_TRAP, 0, T_TRAP);
      do_reset();

      opcode = 6'b000000; funct = 6'b001000;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1);
      exp_ec = 2'b10; exp_ec_b = 2'b10;
      cyc(T_TRAP, 1, T_TRAP); cyc(T_TRAP, 1);
      do_reset();

      // sw stuck in MEM_WR: dut_a traps after 4 waits, dut_b keeps waiting
      opcode = 6'b101011;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_MEM_ADDR, 1);
      for (int i = 0; i < 4; i++) cyc(T_MEM_WR, 0, T_MEM_WR);
      exp_ec = 2'b01;
      cyc(T_TRAP, 0, T_MEM_WR); cyc(T_TRAP, 0); cyc(T_TRAP, 1);
      do_reset();

      // reset abandons a pending load mid-wait
      opcode = 6'b100011;
      cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_MEM_ADDR, 1);
      cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 0);
      do_reset();
      cyc(T_FETCH, 0, T_FETCH); cyc(T_FETCH, 0); cyc(T_FETCH, 0); cyc(T_FETCH, 1);
      cyc(T_DECODE, 1); cyc(T_MEM_ADDR, 1);
      cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 1);
      cyc(T_MEM_WB, 1); cyc(T_FETCH, 1, T_FETCH);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised successor to the single-cycle control unit: drives the shared-memory multicycle datapath as a Moore FSM, one instruction per 3-5+ cycles.
- Adds a variable-latency memory handshake (mem_ready), a memory-wait watchdog, illegal-opcode trapping and an instruction-retire pulse.
- Sits beside the datapath in the top-level processor and replaces the combinational decoder.

Parameters:
- ALU_CTRL_W, 3, width of alu_control; encodings come from the shared package.
- MEM_TIMEOUT, 16, maximum consecutive cycles a memory state may wait with mem_ready=0 before trapping; must be >=1.
- HALFWORD_EN, 1, when 0, lh/sh opcodes decode as illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- opcode  in  6  Instr[31:26] from the instruction register
- funct  in  6  Instr[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory has completed the current access this cycle
- pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, half_word, shift  out  1 each  datapath controls
- alu_src_b  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
- alu_control  out  ALU_CTRL_W  ALU operation
- instr_retired  out  1  one-cycle pulse when an instruction completes
- err  out  1  sticky trap flag
- err_code  out  2  00=none, 01=memory timeout, 10=illegal opcode/funct

Behaviour:
- Clocking and reset: one clock. reset is synchronous and active-high. While reset=1 at a clk edge: state<=FETCH, wait counter<=0, err<=0, err_code<=00. All outputs are 0 during any cycle in which reset=1.
- State set: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, ADDI_EX, ADDI_WB, BRANCH, JUMP, TRAP.
- FETCH:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_control=ADD.
  - ir_write and pc_write are asserted only when mem_ready=1.
  - mem_ready=1 -> DECODE; otherwise stay in FETCH.
- DECODE:
  - alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut).
  - Next state by opcode:
    - 100011 lw / 101011 sw / 100001 lh / 101001 sh -> MEM_ADDR
    - 000000 R-type -> EXEC
    - 001000 addi -> ADDI_EX
    - 000100 beq -> BRANCH
    - 000010 j -> JUMP
    - anything else -> TRAP with err_code=10
  - R-type with a funct outside {100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt, 000000 sll} -> TRAP with err_code=10.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, ADD. Loads -> MEM_RD; stores -> MEM_WR. half_word=1 for lh/sh in MEM_ADDR, MEM_RD, MEM_WB and MEM_WR.
- MEM_RD: iord=1, mem_read=1. mem_ready=1 -> MEM_WB; otherwise wait.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; instr_retired=1; next FETCH.
- MEM_WR:
  - iord=1, mem_write=1 held until mem_ready=1.
  - instr_retired=1 in the mem_ready=1 cycle; next FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct. shift=1 for sll. Next ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1, mem_to_reg=0, alu_control and shift held from EXEC; instr_retired=1; next FETCH.
- ADDI_EX: alu_src_a=1, alu_src_b=10, ADD. Next ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, ADD held; instr_retired=1; next FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_write_cond=1, pc_source=01. Taken iff zero=1 (the datapath gates the write). instr_retired=1; next FETCH.
- JUMP: pc_write=1, pc_source=10; instr_retired=1; next FETCH.
- Watchdog:
  - The counter increments each cycle spent in FETCH/MEM_RD/MEM_WR with mem_ready=0 and clears on any state change.
  - When the counter reaches MEM_TIMEOUT while still waiting -> TRAP with err_code=01.
  - mem_ready=1 in the same cycle the counter would reach MEM_TIMEOUT: the access completes and there is no trap.
- TRAP: all datapath controls 0, err=1; absorbing until reset.
- Reset mid-instruction: any pending memory access or register write is abandoned. The first post-reset cycle is FETCH with a zero counter.

Decomposition:
- Package cpu_ctrl_pkg holds the following; the datapath's ALU shares the encodings.
  - Opcode and funct localparams.
  - ALU encodings: AND=000, OR=001, ADD=010, SLL=011, SUB=110, SLT=111.
  - State enum.
  - err_code values.
- Sub-module alu_decoder (combinational funct -> alu_control/shift/legal) is natural and reusable.

Test Plan:
- lw, mem_ready held 1 from reset release -> states FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB; instr_retired pulses in cycle 5 only; reg_write=1 and mem_to_reg=1 in cycle 5.
- FETCH with mem_ready=0 for 3 cycles then 1, MEM_TIMEOUT=16 -> 4 cycles in FETCH; ir_write and pc_write high only in the 4th; err stays 0.
- MEM_TIMEOUT=4, sw with mem_ready stuck 0 in MEM_WR -> TRAP after 4 wait cycles; err=1, err_code=01; mem_write=0 thereafter until reset.
- opcode 111111; also R-type funct 001000; also lh with HALFWORD_EN=0 -> TRAP from DECODE with err_code=10 in each case.
- beq with zero=1 then zero=0; R-type sub (funct 100010) -> BRANCH asserts pc_write_cond=1, pc_source=01, alu_control=110; R-type takes 4 cycles with reg_dst=1 and alu_control=110 in ALU_WB.
- reset=1 asserted in MEM_RD mid-wait, then released -> next cycle is FETCH with all outputs as FETCH; err=0; a MEM_TIMEOUT-1 wait does not trap.
